i2c_scl_gen: RTL and testbench

//  Parametrised, run-time programmable I2C bit-clock generator; next generation of our fixed clock divider.

---
 rtl/i2c_scl_gen.sv | 155 +++++++++++++++
 tb/tb_i2c_scl_gen.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_scl_gen.sv
// I2C bit-clock generator: divides clk_in into a 4-phase SCL period with one-cycle phase strobes.
// Latency: fall_stb/clk_out low on the edge after en is seen in IDLE; every phase lasts eff=max(div_q,MIN_DIV_Q) cycles.
// Backpressure: a low synchronised scl_in holds the last cycle of phase 2 (clock stretching) for as long as it stays low.
//
// Ports:
//   clk_in    system clock              reset     synchronous active-high reset
//   en        request SCL periods       div_q     quarter-period in clk_in cycles
//   scl_in    bus SCL (asynchronous)    clk_out   generated SCL level (idles high)
//   busy      a period is in progress   stretched phase 2 held by a low scl_in
//   fall_stb / mlow_stb / rise_stb / mhigh_stb   one-cycle strobes at the start of phases 0..3
module i2c_scl_gen #(
    parameter int CNT_W      = 10,
    parameter int MIN_DIV_Q  = 4,
    parameter int STRETCH_EN = 1
) (
    input  logic             clk_in,
    input  logic             reset,
    input  logic             en,
    input  logic [CNT_W-1:0] div_q,
    input  logic             scl_in,
    output logic             clk_out,
    output logic             busy,
    output logic             fall_stb,
    output logic             mlow_stb,
    output logic             rise_stb,
    output logic             mhigh_stb,
    output logic             stretched
);

    typedef enum logic {IDLE, RUN} state_e;

    localparam logic [CNT_W-1:0] MIN_DIV = CNT_W'(MIN_DIV_Q);

    state_e           state_q, state_d;
    logic [1:0]       phase_q, phase_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] eff_q, eff_d;
    logic             clk_q, clk_d;
    logic             fall_q, fall_d;
    logic             mlow_q, mlow_d;
    logic             rise_q, rise_d;
    logic             mhigh_q, mhigh_d;
    logic             sync1_q, sync2_q;

    logic [CNT_W-1:0] eff_in;
    logic             last_cnt;
    logic             scl_ok;

    // Clamp applied before latching so short divisors still cover synchroniser latency.
    assign eff_in   = (div_q < MIN_DIV) ? MIN_DIV : div_q;
    assign last_cnt = (cnt_q == eff_q - CNT_W'(1));
    // With stretching disabled the bus level is ignored entirely.
    assign scl_ok   = (STRETCH_EN == 0) || sync2_q;

    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        cnt_d   = cnt_q;
        eff_d   = eff_q;
        clk_d   = clk_q;
        fall_d  = 1'b0;
        mlow_d  = 1'b0;
        rise_d  = 1'b0;
        mhigh_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (en) begin
                    state_d = RUN;
                    phase_d = 2'd0;
                    cnt_d   = '0;
                    eff_d   = eff_in;
                    clk_d   = 1'b0;
                    fall_d  = 1'b1;
                end
            end
            RUN: begin
                if (!last_cnt) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end else begin
                    case (phase_q)
                        2'd0: begin
                            phase_d = 2'd1;
                            cnt_d   = '0;
                            mlow_d  = 1'b1;
                        end
                        2'd1: begin
                            phase_d = 2'd2;
                            cnt_d   = '0;
                            clk_d   = 1'b1;
                            rise_d  = 1'b1;
                        end
                        2'd2: begin
                            // Counter parks on its last value while the slave holds SCL low.
                            if (scl_ok) begin
                                phase_d = 2'd3;
                                cnt_d   = '0;
                                mhigh_d = 1'b1;
                            end
                        end
                        default: begin
                            // en is only honoured here, so a period is never truncated.
                            phase_d = 2'd0;
                            cnt_d   = '0;
                            if (en) begin
                                eff_d  = eff_in;
                                clk_d  = 1'b0;
                                fall_d = 1'b1;
                            end else begin
                                state_d = IDLE;
                            end
                        end
                    endcase
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (reset) begin
            state_q <= IDLE;
            phase_q <= 2'd0;
            cnt_q   <= '0;
            eff_q   <= MIN_DIV;
            clk_q   <= 1'b1;
            fall_q  <= 1'b0;
            mlow_q  <= 1'b0;
            rise_q  <= 1'b0;
            mhigh_q <= 1'b0;
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            cnt_q   <= cnt_d;
            eff_q   <= eff_d;
            clk_q   <= clk_d;
            fall_q  <= fall_d;
            mlow_q  <= mlow_d;
            rise_q  <= rise_d;
            mhigh_q <= mhigh_d;
            sync1_q <= scl_in;
            sync2_q <= sync1_q;
        end
    end

    assign clk_out   = clk_q;
    assign busy      = (state_q == RUN);
    assign fall_stb  = fall_q;
    assign mlow_stb  = mlow_q;
    assign rise_stb  = rise_q;
    assign mhigh_stb = mhigh_q;
    assign stretched = (state_q == RUN) && (phase_q == 2'd2) && last_cnt && !scl_ok;

endmodule

// File: tb/tb_i2c_scl_gen.sv
module tb_i2c_scl_gen;

    logic       clk_in = 1'b0;
    logic       reset  = 1'b1;
    logic       en     = 1'b0;
    logic [9:0] div_q  = 10'd4;
    logic       scl_in = 1'b1;
    logic       hold   = 1'b0;
    logic       clk_out, busy, fall_stb, mlow_stb, rise_stb, mhigh_stb, stretched;

    i2c_scl_gen #(.CNT_W(10), .MIN_DIV_Q(4), .STRETCH_EN(1)) dut (
        .clk_in   (clk_in),
        .reset    (reset),
        .en       (en),
        .div_q    (div_q),
        .scl_in   (scl_in),
        .clk_out  (clk_out),
        .busy     (busy),
        .fall_stb (fall_stb),
        .mlow_stb (mlow_stb),
        .rise_stb (rise_stb),
        .mhigh_stb(mhigh_stb),
        .stretched(stretched)
    );

    always #5 clk_in = ~clk_in;

    int cyc  = 0;
    int vec  = 0;
    int errs = 0;

    // Reference model: a period is a list of phase start times; each phase ends
    // eff cycles after it started, phase 2 additionally waits for the bus to read high.
    bit         m_run   = 1'b0;
    int         m_ph    = 0;
    int         m_start = 0;
    int         m_eff   = 4;
    logic [3:0] m_stb   = 4'b0;
    logic       m_s1    = 1'b1;
    logic       m_s2    = 1'b1;
    logic       m_sp;
    logic       m_clk   = 1'b1;
    logic       m_str   = 1'b0;

    always @(posedge clk_in) begin
        m_sp = m_s2;               // bus level the design sees during the cycle just ending
        m_s2 = m_s1;
        m_s1 = scl_in;
        cyc  = cyc + 1;
        m_stb = 4'b0;
        if (reset) begin
            m_run = 1'b0;
            m_ph  = 0;
            m_s1  = 1'b1;
            m_s2  = 1'b1;
        end else if (!m_run) begin
            if (en) begin
                m_run = 1'b1; m_ph = 0; m_start = cyc;
                m_eff = (div_q < 10'd4) ? 4 : int'(div_q);
                m_stb[0] = 1'b1;
            end
        end else if ((cyc - 1 - m_start) >= m_eff - 1) begin
            if (m_ph == 2 && !m_sp) begin
                // phase 2 extended by the slave
            end else if (m_ph == 3) begin
                if (en) begin
                    m_ph = 0; m_start = cyc;
                    m_eff = (div_q < 10'd4) ? 4 : int'(div_q);
                    m_stb[0] = 1'b1;
                end else begin
                    m_run = 1'b0;
                    m_ph  = 0;
                end
            end else begin
                m_ph = m_ph + 1; m_start = cyc;
                m_stb[m_ph] = 1'b1;
            end
        end
        m_clk = !m_run || (m_ph >= 2);
        m_str = m_run && (m_ph == 2) && ((cyc - m_start) >= m_eff - 1) && !m_s2;
    end

    wire [6:0] got  = {clk_out, busy, fall_stb, mlow_stb, rise_stb, mhigh_stb, stretched};
    wire [6:0] expv = {m_clk, m_run, m_stb[0], m_stb[1], m_stb[2], m_stb[3], m_str};

    // Bus model: open-drain SCL is low if we drive low or the slave holds it.
    task automatic tick();
        @(negedge clk_in);
        scl_in = m_clk & ~hold;
    endtask

    task automatic drain();
        en = 1'b0;
        for (int i = 0; i < 80 && m_run; i++) tick();
        tick();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        vec++;
        if (got !== 7'b1000000) begin
            errs++; $display("FAIL reset_state got=%b exp=%b", got, 7'b1000000);
        end
        reset = 1'b0;
        tick();
        vec++;
        if (got !== 7'b1000000) begin
            errs++; $display("FAIL reset_idle got=%b exp=%b", got, 7'b1000000);
        end
    endtask

    task automatic test_basic(input string nm, input logic [9:0] dq);
        int t0, rel;
        logic [6:0] ce;
        div_q = dq;
        en    = 1'b1;
        t0    = cyc;
        for (int k = 0; k < 20; k++) begin
            tick();
            rel = cyc - t0;
            ce = {!((rel <= 8) || (rel >= 17)), 1'b1, (rel == 1 || rel == 17),
                  (rel == 5), (rel == 9), (rel == 13), 1'b0};
            vec++;
            if (got !== ce) begin
                errs++; $display("FAIL %s_timing rel=%0d got=%b exp=%b", nm, rel, got, ce);
            end
            vec++;
            if (got !== expv) begin
                errs++; $display("FAIL %s_model cyc=%0d got=%b exp=%b", nm, cyc, got, expv);
            end
        end
        drain();
        vec++;
        if (got !== 7'b1000000) begin
            errs++; $display("FAIL %s_idle got=%b exp=%b", nm, got, 7'b1000000);
        end
    endtask

    task automatic test_stretch();
        int hi, nstr, rcyc, mcyc, k;
        bit seen;
        div_q = 10'd4;
        en    = 1'b1;
        seen  = 1'b0;
        for (k = 0; k < 40 && !seen; k++) begin
            tick();
            seen = rise_stb;
        end
        vec++;
        if (!seen) begin
            errs++; $display("FAIL stretch_rise_timeout got=%b exp=rise_stb", got);
        end
        rcyc = cyc; hi = 1; nstr = 0; mcyc = 0;
        hold = 1'b1;
        scl_in = m_clk & ~hold;
        for (k = 1; k < 40; k++) begin
            if (k == 10) hold = 1'b0;
            tick();
            vec++;
            if (got !== expv) begin
                errs++; $display("FAIL stretch_model cyc=%0d got=%b exp=%b", cyc, got, expv);
            end
            if (stretched) nstr++;
            if (mhigh_stb) mcyc = cyc;
            if (fall_stb) break;
            if (clk_out) hi++;
        end
        vec++;
        if (nstr != 9) begin
            errs++; $display("FAIL stretch_len got=%0d exp=%0d", nstr, 9);
        end
        vec++;
        if (hi != 8 + nstr) begin
            errs++; $display("FAIL stretch_high_time got=%0d exp=%0d", hi, 8 + nstr);
        end
        vec++;
        if (mcyc - rcyc != 4 + nstr) begin
            errs++; $display("FAIL stretch_mhigh_delay got=%0d exp=%0d", mcyc - rcyc, 4 + nstr);
        end
        drain();
    endtask

    task automatic test_en_drop();
        int t0, rel, falls;
        div_q = 10'd4;
        en    = 1'b1;
        t0    = cyc;
        falls = 0;
        for (int k = 0; k < 30; k++) begin
            tick();
            rel = cyc - t0;
            if (rel == 6) en = 1'b0;
            if (rel >= 17 && fall_stb) falls++;
            if (rel == 16) begin
                vec++;
                if (busy !== 1'b1) begin
                    errs++; $display("FAIL endrop_busy16 got=%b exp=1", busy);
                end
            end
            if (rel == 17) begin
                vec++;
                if ({clk_out, busy} !== 2'b10) begin
                    errs++; $display("FAIL endrop_idle17 got=%b exp=10", {clk_out, busy});
                end
            end
            vec++;
            if (got !== expv) begin
                errs++; $display("FAIL endrop_model cyc=%0d got=%b exp=%b", cyc, got, expv);
            end
        end
        vec++;
        if (falls != 0) begin
            errs++; $display("FAIL endrop_no_fall got=%0d exp=0", falls);
        end
    endtask

    task automatic test_div_change();
        int t0, nf;
        int f[3];
        div_q = 10'd4;
        en    = 1'b1;
        t0    = cyc;
        nf    = 0;
        for (int k = 0; k < 80 && nf < 3; k++) begin
            tick();
            if (cyc - t0 == 10) div_q = 10'd6;
            if (fall_stb) begin f[nf] = cyc; nf++; end
            vec++;
            if (got !== expv) begin
                errs++; $display("FAIL divchg_model cyc=%0d got=%b exp=%b", cyc, got, expv);
            end
        end
        vec++;
        if (nf != 3) begin
            errs++; $display("FAIL divchg_timeout got=%0d exp=3 falls", nf);
        end else begin
            vec++;
            if (f[1] - f[0] != 16) begin
                errs++; $display("FAIL divchg_period1 got=%0d exp=16", f[1] - f[0]);
            end
            vec++;
            if (f[2] - f[1] != 24) begin
                errs++; $display("FAIL divchg_period2 got=%0d exp=24", f[2] - f[1]);
            end
        end
        drain();
    endtask

    task automatic test_mid_reset();
        int t0, rel;
        logic [6:0] ce;
        div_q = 10'd4;
        en    = 1'b1;
        for (int k = 0; k < 6; k++) tick();
        reset = 1'b1;
        en    = 1'b0;
        tick();
        vec++;
        if (got !== 7'b1000000) begin
            errs++; $display("FAIL midreset_state got=%b exp=%b", got, 7'b1000000);
        end
        reset = 1'b0;
        en    = 1'b1;
        t0    = cyc;
        for (int k = 0; k < 17; k++) begin
            tick();
            rel = cyc - t0;
            ce = {!((rel <= 8) || (rel >= 17)), 1'b1, (rel == 1 || rel == 17),
                  (rel == 5), (rel == 9), (rel == 13), 1'b0};
            vec++;
            if (got !== ce) begin
                errs++; $display("FAIL midreset_rerun rel=%0d got=%b exp=%b", rel, got, ce);
            end
        end
        drain();
    endtask

    task automatic test_random();
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(0, 24) == 0) div_q = 10'($urandom_range(0, 9));
            if ($urandom_range(0, 19) == 0) en = ~en;
            if ($urandom_range(0, 14) == 0) hold = ~hold;
            reset = ($urandom_range(0, 299) == 0);
            tick();
            vec++;
            if (got !== expv) begin
                errs++; $display("FAIL random_model cyc=%0d got=%b exp=%b", cyc, got, expv);
            end
        end
        reset = 1'b0;
        hold  = 1'b0;
        drain();
    endtask

    initial begin
        test_reset();
        test_basic("basic", 10'd4);
        test_basic("clamp2", 10'd2);
        test_basic("clamp0", 10'd0);
        test_stretch();
        test_en_drop();
        test_div_change();
        test_mid_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

endmodule
